// File: rtl/poly_conv_engine.sv
// Sequential linear-convolution engine: streams in h then x, emits y[k] using one MAC per cycle.
// Define POLY_CONV_SAT_EN for unsigned saturation of out_data; by default results wrap modulo 2^OUT_W.
module poly_conv_engine #(
  parameter int DATA_W = 4,
  parameter int LEN_X  = 4,
  parameter int LEN_H  = 4,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              reuse_h,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int MIN_LEN = (LEN_X < LEN_H) ? LEN_X : LEN_H;
  localparam int ACC_W   = 2 * DATA_W + $clog2(MIN_LEN) + 1;
  localparam int K_W     = $clog2(LEN_X + LEN_H);
  localparam int XI_W    = (LEN_X > 1) ? $clog2(LEN_X) : 1;
  localparam int HI_W    = (LEN_H > 1) ? $clog2(LEN_H) : 1;

  localparam logic [K_W-1:0] LAST_K = K_W'(LEN_X + LEN_H - 2);
  localparam logic [K_W-1:0] H_TOP  = K_W'(LEN_H - 1);
  localparam logic [K_W-1:0] X_TOP  = K_W'(LEN_X - 1);

  typedef enum logic [1:0] {LOAD_H, LOAD_X, COMPUTE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] h_mem [LEN_H];
  logic [DATA_W-1:0] x_mem [LEN_X];

  logic [K_W-1:0]      idx, k, j;
  logic [K_W-1:0]      jhi, k_nxt, jlo_nxt;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   x_term, h_term;
  logic [2*DATA_W-1:0] prod;
  logic [OUT_W-1:0]    acc_fit;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Term window for the current k, and the k/jlo that the next COMPUTE entry will start from.
  always_comb begin
    jhi     = (k < X_TOP) ? k : X_TOP;
    k_nxt   = (state == OUTPUT) ? k + K_W'(1) : '0;
    jlo_nxt = (k_nxt > H_TOP) ? k_nxt - H_TOP : '0;
    x_term  = x_mem[XI_W'(j)];
    h_term  = h_mem[HI_W'(k - j)];
    prod    = {{DATA_W{1'b0}}, x_term} * {{DATA_W{1'b0}}, h_term};
  end

`ifdef POLY_CONV_SAT_EN
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [EXT_W-1:0] OUT_MAX = EXT_W'({OUT_W{1'b1}});
  logic [EXT_W-1:0] acc_ext;
  always_comb begin
    acc_ext = EXT_W'(acc);
    acc_fit = (acc_ext > OUT_MAX) ? {OUT_W{1'b1}} : OUT_W'(acc_ext);
  end
`else
  always_comb acc_fit = OUT_W'(acc);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD_H;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_H:  if (in_fire && idx == H_TOP) state_nxt = LOAD_X;
      LOAD_X:  if (in_fire && idx == X_TOP) state_nxt = COMPUTE;
      COMPUTE: if (j == jhi) state_nxt = OUTPUT;
      OUTPUT: begin
        if (out_fire) begin
          if (k != LAST_K)  state_nxt = COMPUTE;
          else if (reuse_h) state_nxt = LOAD_X;
          else              state_nxt = LOAD_H;
        end
      end
      default: state_nxt = LOAD_H;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD_H) || (state == LOAD_X);
    out_valid = (state == OUTPUT);
    out_last  = (state == OUTPUT) && (k == LAST_K);
    busy      = (state == COMPUTE) || (state == OUTPUT);
    out_data  = (state == OUTPUT) ? acc_fit : '0;
  end

  // Sample storage needs no reset; contents are rewritten before they are ever read.
  always_ff @(posedge clk) begin
    if (state == LOAD_H && in_fire) h_mem[HI_W'(idx)] <= in_data;
    if (state == LOAD_X && in_fire) x_mem[XI_W'(idx)] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      k   <= '0;
      j   <= '0;
      acc <= '0;
    end else begin
      unique case (state)
        LOAD_H: begin
          if (in_fire) idx <= (idx == H_TOP) ? '0 : idx + K_W'(1);
        end
        LOAD_X: begin
          if (in_fire) begin
            if (idx == X_TOP) begin
              idx <= '0;
              k   <= k_nxt;
              j   <= jlo_nxt;
              acc <= '0;
            end else begin
              idx <= idx + K_W'(1);
            end
          end
        end
        COMPUTE: begin
          acc <= acc + ACC_W'(prod);
          if (j != jhi) j <= j + K_W'(1);
        end
        OUTPUT: begin
          if (out_fire && k != LAST_K) begin
            k   <= k_nxt;
            j   <= jlo_nxt;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
